muldiv_iter_unit: RTL

- Parametrised iterative multiply/divide engine for the execute stage; next generation of the fixed 32-bit in-ALU mul/div.
- Computes MULT/MULTU/DIV/DIVU on WIDTH-bit operands and returns a 2*WIDTH result as {hi, lo} for the HI/LO register write.
- Adds a configurable throughput per cycle, explicit start/done/ack handshake, flush cancellation and a defined divide-by-zero result.
- The hazard unit stalls E while busy is high.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_if.sv | 29 ++
 rtl/div_restore_step.sv | 23 ++
 rtl/muldiv_iter_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and state encodings shared by the
// iterative multiply/divide unit and its interface.
package muldiv_pkg;

  typedef logic [1:0] md_op_t;

  localparam md_op_t MD_MULT  = 2'b00;
  localparam md_op_t MD_MULTU = 2'b01;
  localparam md_op_t MD_DIV   = 2'b10;
  localparam md_op_t MD_DIVU  = 2'b11;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  function automatic logic md_is_div(md_op_t op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(md_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the execute
// stage (master) and the mul/div unit (slave).
interface muldiv_if #(
  parameter int WIDTH = 32
) ();
  import muldiv_pkg::*;

  logic             flush;
  logic             start;
  md_op_t           op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ack;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output flush, start, op, a, b, ack,
    input  busy, done, hi, lo
  );

  modport slave (
    input  flush, start, op, a, b, ack,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/div_restore_step.sv
// div_restore_step: one restoring-division step on the
// {remainder, quotient} pair against the divisor.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  // rem_i < dvs_i holds, so diff[WIDTH] is the borrow
  assign sh    = {rem_i, quo_i[WIDTH-1]};
  assign diff  = sh - {1'b0, dvs_i};
  assign rem_o = diff[WIDTH] ? sh[WIDTH-1:0]
                             : diff[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/muldiv_iter_unit.sv
// muldiv_iter_unit: iterative MULT/MULTU/DIV/DIVU engine
// with start/done/ack handshake and flush cancel.
module muldiv_iter_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1,
  parameter int DIV_STEP = 1
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave md
);

  localparam int W2 = 2 * WIDTH;
  localparam int WM = WIDTH + MUL_STEP;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_LAST =
    CW'(WIDTH / MUL_STEP - 1);
  localparam logic [CW-1:0] DIV_LAST =
    CW'(WIDTH / DIV_STEP - 1);

  logic [1:0]       state_q, state_d;
  md_op_t           op_q, op_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             dz_q, dz_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             is_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  assign is_div = md_is_div(md.op);
  assign a_neg  = md_is_signed(md.op) & md.a[WIDTH-1];
  assign b_neg  = md_is_signed(md.op) & md.b[WIDTH-1];
  assign a_abs  = a_neg ? -md.a : md.a;
  assign b_abs  = b_neg ? -md.b : md.b;

  // acc = {partial high, remaining multiplier bits}
  logic [MUL_STEP-1:0] mbits;
  logic [WM-1:0]       mpart;
  logic [WM-1:0]       msum;
  logic [W2-1:0]       mul_nxt;

  assign mbits   = acc_q[MUL_STEP-1:0];
  assign mpart   = WM'(opnd_q) * WM'(mbits);
  assign msum    = WM'(acc_q[W2-1:WIDTH]) + mpart;
  assign mul_nxt = {msum, acc_q[WIDTH-1:MUL_STEP]};

  // acc = {remainder, dividend/quotient}
  for (genvar i = 0; i < DIV_STEP; i++) begin : g_div
    logic [WIDTH-1:0] rem_in, quo_in;
    logic [WIDTH-1:0] rem_out, quo_out;
    if (i == 0) begin : g_first
      assign rem_in = acc_q[W2-1:WIDTH];
      assign quo_in = acc_q[WIDTH-1:0];
    end else begin : g_next
      assign rem_in = g_div[i-1].rem_out;
      assign quo_in = g_div[i-1].quo_out;
    end
    div_restore_step #(
      .WIDTH (WIDTH)
    ) u_step (
      .rem_i (rem_in),
      .quo_i (quo_in),
      .dvs_i (opnd_q),
      .rem_o (rem_out),
      .quo_o (quo_out)
    );
  end

  logic [W2-1:0] div_nxt;
  assign div_nxt = {g_div[DIV_STEP-1].rem_out,
                    g_div[DIV_STEP-1].quo_out};

  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo_fix  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0]
                                  : acc_q[WIDTH-1:0];
  assign rem_fix  = sa_q ? -acc_q[W2-1:WIDTH]
                         : acc_q[W2-1:WIDTH];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (md.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (md.start) begin
            op_d   = md.op;
            sa_d   = a_neg;
            sb_d   = b_neg;
            cnt_d  = '0;
            dz_d   = is_div & (md.b == '0);
            opnd_d = is_div ? b_abs : a_abs;
            if (is_div & (md.b == '0)) begin
              // raw dividend kept for the hi result
              acc_d   = {md.a, {WIDTH{1'b1}}};
              state_d = FIXUP;
            end else begin
              acc_d   = {{WIDTH{1'b0}},
                         is_div ? a_abs : b_abs};
              state_d = RUN;
            end
          end
        end
        RUN: begin
          cnt_d = cnt_q + CW'(1);
          acc_d = md_is_div(op_q) ? div_nxt : mul_nxt;
          if (cnt_q == (md_is_div(op_q) ? DIV_LAST
                                        : MUL_LAST)) begin
            state_d = FIXUP;
          end
        end
        FIXUP: begin
          state_d = DONE;
          if (dz_q) begin
            {hi_d, lo_d} = acc_q;
          end else if (md_is_div(op_q)) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
        DONE: begin
          if (md.ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.busy = (state_q == RUN) | (state_q == FIXUP);
  assign md.done = (state_q == DONE);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
